stage_queue: RTL and testbench

STAGE_QUEUE -- requirements
Module: stage_queue

---
 rtl/stage_queue_pkg.sv | 20 ++
 rtl/stage_queue.sv | 94 +++++++++
 tb/tb_stage_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stage_queue_pkg.sv
// Shared helpers for the multi-lane stage queue: width calculation and lane counting.
package stage_queue_pkg;

  localparam int unsigned MACHINE_WIDTH = 2;
  localparam int unsigned MAX_LANES     = 32;

  // Ceiling log2, never below 1 so that derived vectors always have a bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned lane_popcount(input logic [MAX_LANES-1:0] v);
    int unsigned n = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/stage_queue.sv
// Multi-lane circular queue: up to LANES entries pushed and popped per cycle, with flush.
module stage_queue
  import stage_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = MACHINE_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*WIDTH-1:0]      in_data,
  output logic                        in_ready,
  output logic [LANES-1:0]            out_valid,
  output logic [LANES*WIDTH-1:0]      out_data,
  input  logic [log2(LANES+1)-1:0]    out_pop,
  output logic [log2(DEPTH+1)-1:0]    count,
  output logic                        empty
);

  localparam int unsigned PtrW = log2(DEPTH);
  localparam int unsigned CntW = log2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  push_cnt, pop_cnt;
  logic             push_en;

  // Readiness only looks at registered occupancy so it never depends on out_pop.
  assign in_ready = count_q <= CntW'(DEPTH - LANES);
  assign push_en  = in_ready && in_valid[0] && !flush;
  assign push_cnt = push_en ? CntW'(lane_popcount(MAX_LANES'(in_valid))) : '0;
  assign pop_cnt  = CntW'(out_pop);
  assign count    = count_q;
  assign empty    = (count_q == '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      tail_d  = tail_q + PtrW'(push_cnt);
      head_d  = head_q + PtrW'(out_pop);
      count_d = count_q + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally left uncleared; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (in_valid[i]) mem_q[tail_q + PtrW'(i)] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_valid[i]               = count_q > CntW'(i);
      out_data[i*WIDTH +: WIDTH] = mem_q[head_q + PtrW'(i)];
    end
  end

`ifndef SYNTHESIS
  a_in_valid_contig: assert property (@(posedge clk) disable iff (!resetn)
    (in_valid & (in_valid + LANES'(1))) == '0)
    else $error("in_valid lanes not contiguous from lane 0");

  a_pop_legal: assert property (@(posedge clk) disable iff (!resetn)
    32'(out_pop) <= lane_popcount(MAX_LANES'(out_valid)))
    else $error("out_pop exceeds valid output lanes");
`endif

endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue: stimulus queues expected entries, a negedge monitor checks them.
module tb_stage_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_pop = '0;
  logic [3:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  stage_queue #(.WIDTH(32), .LANES(2), .DEPTH(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_pop   (out_pop),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: sb mirrors queue contents; compare presented lanes, then retire popped ones.
  always @(negedge clk) begin
    if (resetn) begin
      check("mon_out_valid", {62'd0, out_valid},
            {62'd0, sb.size() > 1, sb.size() > 0});
      for (int i = 0; i < 2; i++) begin
        if (i < sb.size()) check("mon_lane_data", {32'd0, out_data[i*32 +: 32]}, {32'd0, sb[i]});
      end
      if (!flush) begin
        for (int i = 0; i < int'(out_pop); i++) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_underflow: got pop with empty model want none");
          end else begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus; acc says whether the hand-derived expectation is acceptance.
  task automatic cycle(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] pop, input logic fl, input logic acc);
    in_valid = v;
    in_data  = {d1, d0};
    out_pop  = pop;
    flush    = fl;
    @(posedge clk);
    if (fl) sb.delete();
    if (acc) begin
      if (v[0]) sb.push_back(d0);
      if (v[1]) sb.push_back(d1);
    end
    #1;
    in_valid = '0;
    in_data  = '0;
    out_pop  = '0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_count", {60'd0, count}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_out_valid", {62'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // First push visible the next cycle.
    cycle(2'b11, 32'hA0, 32'hA1, 2'd0, 1'b0, 1'b1);
    check("p1_out_valid", {62'd0, out_valid}, 64'h3);
    check("p1_lane0", {32'd0, out_data[31:0]}, 64'hA0);
    check("p1_lane1", {32'd0, out_data[63:32]}, 64'hA1);
    check("p1_count", {60'd0, count}, 64'd2);
    cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    check("drain_empty", {63'd0, empty}, 64'd1);

    // Fill to full, then a push alongside a pop is dropped.
    for (int k = 0; k < 4; k++)
      cycle(2'b11, 32'h10 + 32'(2*k), 32'h11 + 32'(2*k), 2'd0, 1'b0, 1'b1);
    check("full_count", {60'd0, count}, 64'd8);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    cycle(2'b11, 32'h18, 32'h19, 2'd2, 1'b0, 1'b0);
    check("drop_count", {60'd0, count}, 64'd6);
    check("drop_in_ready", {63'd0, in_ready}, 64'd1);

    // Single-lane push to 7, one more single push is dropped.
    cycle(2'b01, 32'h20, 32'h0, 2'd0, 1'b0, 1'b1);
    check("c7_count", {60'd0, count}, 64'd7);
    check("c7_in_ready", {63'd0, in_ready}, 64'd0);
    cycle(2'b01, 32'h21, 32'h0, 2'd0, 1'b0, 1'b0);
    check("c7_drop_count", {60'd0, count}, 64'd7);
    cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    check("c6_count", {60'd0, count}, 64'd6);
    cycle(2'b11, 32'h22, 32'h23, 2'd0, 1'b0, 1'b1);
    check("c8_count", {60'd0, count}, 64'd8);

    // Drain, then walk pointers to 7 for the wrap case.
    for (int k = 0; k < 4; k++) cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    check("drain2_count", {60'd0, count}, 64'd0);
    cycle(2'b11, 32'hC0, 32'hC1, 2'd0, 1'b0, 1'b1);
    cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    cycle(2'b11, 32'hB0, 32'hB1, 2'd0, 1'b0, 1'b1);
    check("wrap_lane0", {32'd0, out_data[31:0]}, 64'hB0);
    check("wrap_lane1", {32'd0, out_data[63:32]}, 64'hB1);
    cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    check("wrap_pop_lane0", {32'd0, out_data[31:0]}, 64'hB1);
    check("wrap_pop_valid", {62'd0, out_valid}, 64'h1);
    cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    check("wrap_empty", {63'd0, empty}, 64'd1);

    // Flush wins over a same-cycle push and pop.
    cycle(2'b11, 32'h40, 32'h41, 2'd0, 1'b0, 1'b1);
    cycle(2'b11, 32'h42, 32'h43, 2'd0, 1'b0, 1'b1);
    cycle(2'b01, 32'h44, 32'h0, 2'd0, 1'b0, 1'b1);
    check("pre_flush_count", {60'd0, count}, 64'd5);
    cycle(2'b11, 32'h50, 32'h51, 2'd2, 1'b1, 1'b0);
    check("flush_count", {60'd0, count}, 64'd0);
    check("flush_empty", {63'd0, empty}, 64'd1);
    check("flush_out_valid", {62'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(2'b11, 32'h60, 32'h61, 2'd0, 1'b0, 1'b1);
    check("post_flush_lane0", {32'd0, out_data[31:0]}, 64'h60);

    // Asynchronous reset between edges with four entries held.
    cycle(2'b11, 32'h62, 32'h63, 2'd0, 1'b0, 1'b1);
    check("pre_rst_count", {60'd0, count}, 64'd4);
    #2 resetn = 1'b0;
    sb.delete();
    #1;
    check("arst_count", {60'd0, count}, 64'd0);
    check("arst_out_valid", {62'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #3 resetn = 1'b1;
    cycle(2'b11, 32'h70, 32'h71, 2'd0, 1'b0, 1'b1);
    check("post_rst_count", {60'd0, count}, 64'd2);
    check("post_rst_lane1", {32'd0, out_data[63:32]}, 64'h71);
    cycle(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
